phy_lane_fault_injector: RTL and testbench

- Synthesizable, N-channel fault injector between endpoint PHY TX outputs (16-bit data + 2-bit K) and the switch PHY RX inputs.
- Each channel passes traffic through by default. It can also:
  - force a link-kill (idle substitution plus encoding-error flag);
  - run a timed burst fault: wait a programmable delay, then corrupt a programmable number of words in one of four modes.
- Each channel tracks 8b10b running disparity of its output and counts injected words.
- Used in switch-level testbenches and on-board link-robustness tests.

---
 rtl/phy_fault_pkg.sv | 40 ++++
 rtl/phy_lane_fault_chan.sv | 125 ++++++++++++
 rtl/phy_lane_fault_injector.sv | 56 +++++
 tb/tb_phy_lane_fault_injector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_fault_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phy_fault_pkg : shared modes, burst state type and 8b10b disparity helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package phy_fault_pkg;

  localparam logic [1:0] c_MODE_IDLE_SUBST = 2'b00;
  localparam logic [1:0] c_MODE_BITFLIP    = 2'b01;
  localparam logic [1:0] c_MODE_K_INVERT   = 2'b10;
  localparam logic [1:0] c_MODE_ZERO       = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_INJECT = 2'd2
  } t_inj_state;

  // Bit x set when the 6b (indexed by EDCBA) or 4b (indexed by HGF) sub-block
  // is unbalanced, i.e. emitting it flips running disparity.
  localparam logic [31:0] c_UNB6_D = 32'hE981_8117;
  localparam logic [31:0] c_UNB6_K = 32'hF981_8117;
  localparam logic [7:0]  c_UNB4   = 8'h91;

  function automatic logic f_next_8b10b_disparity8(input logic rd_i, input logic k_i,
                                                   input logic [7:0] d_i);
    logic [31:0] tab6;
    tab6 = k_i ? c_UNB6_K : c_UNB6_D;
    return rd_i ^ tab6[d_i[4:0]] ^ c_UNB4[d_i[7:5]];
  endfunction

  function automatic logic f_next_8b10b_disparity16(input logic rd_i, input logic [1:0] k_i,
                                                    input logic [15:0] d_i);
    logic rd_mid;
    rd_mid = f_next_8b10b_disparity8(rd_i, k_i[1], d_i[15:8]);
    return f_next_8b10b_disparity8(rd_mid, k_i[0], d_i[7:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/phy_lane_fault_chan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phy_lane_fault_chan : one lane of burst/kill fault injection with disparity
// Rev 1.0
// ---------------------------------------------------------------------------
module phy_lane_fault_chan
  import phy_fault_pkg::*;
#(
  parameter logic [15:0] g_idle_word = 16'h00BC,
  parameter logic [1:0]  g_idle_k    = 2'b01,
  parameter logic [15:0] g_flip_mask = 16'h0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] tx_data_i,
  input  logic [1:0]  tx_k_i,
  input  logic        link_kill_i,
  input  logic        inj_start_i,
  input  logic [1:0]  inj_mode_i,
  input  logic [15:0] inj_delay_i,
  input  logic [15:0] inj_len_i,
  output logic [15:0] tx_data_o,
  output logic [1:0]  tx_k_o,
  output logic        inj_busy_o,
  output logic        tx_enc_err_o,
  output logic        tx_disparity_o,
  output logic [15:0] inj_cnt_o
);

  t_inj_state  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic [15:0] lcnt_q, lcnt_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  k_q, k_d;
  logic        err_q, err_d;
  logic        disp_q, disp_d;
  logic [15:0] cnt_q, cnt_d;
  logic        inject;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      dcnt_q  <= 16'd0;
      lcnt_q  <= 16'd0;
      data_q  <= 16'd0;
      k_q     <= 2'b00;
      err_q   <= 1'b0;
      disp_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dcnt_q  <= dcnt_d;
      lcnt_q  <= lcnt_d;
      data_q  <= data_d;
      k_q     <= k_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dcnt_d  = dcnt_q;
    lcnt_d  = lcnt_q;
    inject  = (state_q == S_INJECT);
    case (state_q)
      S_IDLE: begin
        if (inj_start_i && (inj_len_i != 16'd0)) begin
          mode_d = inj_mode_i;
          lcnt_d = inj_len_i;
          if (inj_delay_i == 16'd0) begin
            state_d = S_INJECT;
          end else begin
            state_d = S_WAIT;
            dcnt_d  = inj_delay_i - 16'd1;
          end
        end
      end
      S_WAIT: begin
        if (dcnt_q == 16'd0) state_d = S_INJECT;
        else                 dcnt_d  = dcnt_q - 16'd1;
      end
      S_INJECT: begin
        if (lcnt_q == 16'd1) state_d = S_IDLE;
        else                 lcnt_d  = lcnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Kill overrides any burst corruption but the burst keeps sequencing.
  always_comb begin
    data_d = tx_data_i;
    k_d    = tx_k_i;
    if (inject) begin
      case (mode_q)
        c_MODE_IDLE_SUBST: begin data_d = g_idle_word;             k_d = g_idle_k; end
        c_MODE_BITFLIP:    begin data_d = tx_data_i ^ g_flip_mask;                 end
        c_MODE_K_INVERT:   begin                                   k_d = ~tx_k_i;  end
        default:           begin data_d = 16'd0;                   k_d = 2'b00;    end
      endcase
    end
    if (link_kill_i) begin
      data_d = g_idle_word;
      k_d    = g_idle_k;
    end
    err_d  = link_kill_i;
    disp_d = f_next_8b10b_disparity16(disp_q, k_d, data_d);
    cnt_d  = (inject && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  assign tx_data_o      = data_q;
  assign tx_k_o         = k_q;
  assign inj_busy_o     = (state_q != S_IDLE);
  assign tx_enc_err_o   = err_q;
  assign tx_disparity_o = disp_q;
  assign inj_cnt_o      = cnt_q;

endmodule
`default_nettype wire

// File: rtl/phy_lane_fault_injector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phy_lane_fault_injector : N independent PHY lane fault injectors
// Rev 1.0
// ---------------------------------------------------------------------------
module phy_lane_fault_injector
  import phy_fault_pkg::*;
#(
  parameter int          g_num_ports = 6,
  parameter logic [15:0] g_idle_word = 16'h00BC,
  parameter logic [1:0]  g_idle_k    = 2'b01,
  parameter logic [15:0] g_flip_mask = 16'h0001
) (
  input  logic                      clk_ref_i,
  input  logic                      rst_i,
  input  logic [16*g_num_ports-1:0] tx_data_i,
  input  logic [2*g_num_ports-1:0]  tx_k_i,
  output logic [16*g_num_ports-1:0] tx_data_o,
  output logic [2*g_num_ports-1:0]  tx_k_o,
  input  logic [g_num_ports-1:0]    link_kill_i,
  input  logic [g_num_ports-1:0]    inj_start_i,
  input  logic [2*g_num_ports-1:0]  inj_mode_i,
  input  logic [16*g_num_ports-1:0] inj_delay_i,
  input  logic [16*g_num_ports-1:0] inj_len_i,
  output logic [g_num_ports-1:0]    inj_busy_o,
  output logic [g_num_ports-1:0]    tx_enc_err_o,
  output logic [g_num_ports-1:0]    tx_disparity_o,
  output logic [16*g_num_ports-1:0] inj_cnt_o
);

  for (genvar j = 0; j < g_num_ports; j++) begin : g_chan
    phy_lane_fault_chan #(
      .g_idle_word (g_idle_word),
      .g_idle_k    (g_idle_k),
      .g_flip_mask (g_flip_mask)
    ) u_chan (
      .clk_i          (clk_ref_i),
      .rst_i          (rst_i),
      .tx_data_i      (tx_data_i[16*j +: 16]),
      .tx_k_i         (tx_k_i[2*j +: 2]),
      .link_kill_i    (link_kill_i[j]),
      .inj_start_i    (inj_start_i[j]),
      .inj_mode_i     (inj_mode_i[2*j +: 2]),
      .inj_delay_i    (inj_delay_i[16*j +: 16]),
      .inj_len_i      (inj_len_i[16*j +: 16]),
      .tx_data_o      (tx_data_o[16*j +: 16]),
      .tx_k_o         (tx_k_o[2*j +: 2]),
      .inj_busy_o     (inj_busy_o[j]),
      .tx_enc_err_o   (tx_enc_err_o[j]),
      .tx_disparity_o (tx_disparity_o[j]),
      .inj_cnt_o      (inj_cnt_o[16*j +: 16])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_lane_fault_injector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_phy_lane_fault_injector : directed self-checking bench, 6 lanes
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_phy_lane_fault_injector;

  localparam int N = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [16*N-1:0] tx_data, tx_data_out, inj_delay, inj_len, inj_cnt;
  logic [2*N-1:0]  tx_k, tx_k_out, inj_mode;
  logic [N-1:0]    link_kill, inj_start, busy, enc_err, disp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phy_lane_fault_injector #(.g_num_ports(N)) dut (
    .clk_ref_i      (clk),
    .rst_i          (rst),
    .tx_data_i      (tx_data),
    .tx_k_i         (tx_k),
    .tx_data_o      (tx_data_out),
    .tx_k_o         (tx_k_out),
    .link_kill_i    (link_kill),
    .inj_start_i    (inj_start),
    .inj_mode_i     (inj_mode),
    .inj_delay_i    (inj_delay),
    .inj_len_i      (inj_len),
    .inj_busy_o     (busy),
    .tx_enc_err_o   (enc_err),
    .tx_disparity_o (disp),
    .inj_cnt_o      (inj_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent 8b10b reference: which 5b/3b sub-block values flip disparity.
  function automatic logic tb_disp8(input logic rd, input logic k, input logic [7:0] b);
    logic u6, u4;
    case (b[4:0])
      5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16, 5'd23,
      5'd24, 5'd27, 5'd29, 5'd30, 5'd31: u6 = 1'b1;
      5'd28:   u6 = k;
      default: u6 = 1'b0;
    endcase
    case (b[7:5])
      3'd0, 3'd4, 3'd7: u4 = 1'b1;
      default:          u4 = 1'b0;
    endcase
    return rd ^ u6 ^ u4;
  endfunction

  function automatic logic tb_disp16(input logic rd, input logic [1:0] k, input logic [15:0] d);
    return tb_disp8(tb_disp8(rd, k[1], d[15:8]), k[0], d[7:0]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    tx_data   = '0;
    tx_k      = '0;
    link_kill = '0;
    inj_start = '0;
    inj_mode  = '0;
    inj_delay = '0;
    inj_len   = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic arm(input int ch, input logic [1:0] mode, input logic [15:0] dly,
                     input logic [15:0] len);
    inj_start[ch]          = 1'b1;
    inj_mode[2*ch +: 2]    = mode;
    inj_delay[16*ch +: 16] = dly;
    inj_len[16*ch +: 16]   = len;
  endtask

  logic [15:0] s_in_d[N], s_exp_d[N];
  logic [1:0]  s_in_k[N], s_exp_k[N];
  logic        e_disp;
  bit          timed_out;

  initial begin
    // Reset state and one-word pass-through on ch0
    do_reset;
    chk("rst_data", tx_data_out, '0);
    chk("rst_k", tx_k_out, '0);
    chk("rst_busy", busy, '0);
    chk("rst_err", enc_err, '0);
    chk("rst_disp", disp, '0);
    chk("rst_cnt", inj_cnt, '0);
    tx_data[15:0] = 16'h1234;
    tick;
    tx_data[15:0] = 16'h0000;
    chk("pt_data", tx_data_out[15:0], 16'h1234);
    chk("pt_k", tx_k_out[1:0], 2'b00);
    chk("pt_disp", disp, 6'b000001);
    chk("pt_cnt0", inj_cnt[15:0], 16'd0);
    tick;
    chk("pt_zero", tx_data_out[15:0], 16'h0000);
    chk("pt_disp_hold", disp[0], 1'b1);

    // Link kill on ch2 for 10 cycles, ch1 passing 4321
    do_reset;
    tx_data[31:16] = 16'h4321;
    link_kill[2]   = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick;
      if (e == 9) link_kill[2] = 1'b0;
      chk($sformatf("kill_err_e%0d", e), enc_err, (e <= 9) ? 6'b000100 : 6'b000000);
      chk($sformatf("kill_data_e%0d", e), tx_data_out[47:32], (e <= 9) ? 16'h00BC : 16'h0000);
      chk($sformatf("kill_k_e%0d", e), tx_k_out[5:4], (e <= 9) ? 2'b01 : 2'b00);
      chk($sformatf("kill_disp_e%0d", e), disp[2], (e <= 9) ? 1'((e + 1) & 1) : 1'b0);
      chk($sformatf("kill_ch1_e%0d", e), tx_data_out[31:16], 16'h4321);
    end

    // BITFLIP on ch1, delay 5, len 3, constant A5A5
    do_reset;
    tx_data[31:16] = 16'hA5A5;
    arm(1, 2'b01, 16'd5, 16'd3);
    tick;
    inj_start = '0;
    for (int e = 0; e <= 10; e++) begin
      if (e > 0) tick;
      chk($sformatf("bf_busy_e%0d", e), busy[1], (e <= 7));
      chk($sformatf("bf_data_e%0d", e), tx_data_out[31:16],
          (e >= 6 && e <= 8) ? 16'hA5A4 : 16'hA5A5);
    end
    chk("bf_cnt", inj_cnt[31:16], 16'd3);
    chk("bf_disp", disp[1], 1'b1);

    // Zero-length start is ignored
    do_reset;
    tx_data[63:48] = 16'h7777;
    arm(3, 2'b11, 16'd0, 16'd0);
    tick;
    inj_start = '0;
    for (int e = 0; e < 4; e++) begin
      if (e > 0) tick;
      chk($sformatf("len0_busy_e%0d", e), busy[3], 1'b0);
      chk($sformatf("len0_data_e%0d", e), tx_data_out[63:48], 16'h7777);
    end
    chk("len0_cnt", inj_cnt[63:48], 16'd0);

    // Second start during WAIT is ignored
    do_reset;
    tx_data[31:16] = 16'h1111;
    arm(1, 2'b11, 16'd3, 16'd2);
    tick;
    arm(1, 2'b01, 16'd0, 16'd5);
    for (int e = 0; e <= 7; e++) begin
      if (e > 0) tick;
      if (e == 1) inj_start = '0;
      chk($sformatf("rearm_busy_e%0d", e), busy[1], (e <= 4));
      chk($sformatf("rearm_data_e%0d", e), tx_data_out[31:16],
          (e == 4 || e == 5) ? 16'h0000 : 16'h1111);
    end
    chk("rearm_cnt", inj_cnt[31:16], 16'd2);

    // Simultaneous single-word bursts, all modes, ch5 untouched
    do_reset;
    s_in_d  = '{16'h1234, 16'hA5A5, 16'hBCBC, 16'hFFFF, 16'h0F0F, 16'h5A5A};
    s_in_k  = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00};
    s_exp_d = '{16'h00BC, 16'hA5A4, 16'hBCBC, 16'h0000, 16'h0F0E, 16'h5A5A};
    s_exp_k = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00};
    arm(0, 2'b00, 16'd0, 16'd1);
    arm(1, 2'b01, 16'd0, 16'd1);
    arm(2, 2'b10, 16'd0, 16'd1);
    arm(3, 2'b11, 16'd0, 16'd1);
    arm(4, 2'b01, 16'd0, 16'd1);
    tick;
    inj_start = '0;
    chk("sim_busy", busy, 6'b011111);
    for (int j = 0; j < N; j++) begin
      tx_data[16*j +: 16] = s_in_d[j];
      tx_k[2*j +: 2]      = s_in_k[j];
    end
    tick;
    tx_data = '0;
    tx_k    = '0;
    for (int j = 0; j < N; j++) begin
      e_disp = tb_disp16(1'b0, s_exp_k[j], s_exp_d[j]);
      chk($sformatf("sim_data_ch%0d", j), tx_data_out[16*j +: 16], s_exp_d[j]);
      chk($sformatf("sim_k_ch%0d", j), tx_k_out[2*j +: 2], s_exp_k[j]);
      chk($sformatf("sim_disp_ch%0d", j), disp[j], e_disp);
      chk($sformatf("sim_cnt_ch%0d", j), inj_cnt[16*j +: 16], (j < 5) ? 16'd1 : 16'd0);
    end
    chk("sim_busy_done", busy, 6'b000000);

    // K_INVERT on ch4: full 65535-word burst, then one more to show saturation
    do_reset;
    tx_k[9:8] = 2'b01;
    arm(4, 2'b10, 16'd0, 16'hFFFF);
    tick;
    inj_start = '0;
    tick;
    chk("kinv_k", tx_k_out[9:8], 2'b10);
    timed_out = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if (!busy[4]) begin
        timed_out = 1'b0;
        break;
      end
      tick;
    end
    chk("sat_timeout", timed_out, 1'b0);
    tick;
    chk("sat_cnt_full", inj_cnt[79:64], 16'hFFFF);
    arm(4, 2'b10, 16'd0, 16'd5);
    tick;
    inj_start = '0;
    for (int e = 0; e < 8; e++) tick;
    chk("sat_cnt_hold", inj_cnt[79:64], 16'hFFFF);

    // Reset 100 cycles into a ch0 IDLE_SUBST burst
    do_reset;
    tx_data[15:0] = 16'h1234;
    arm(0, 2'b00, 16'd0, 16'd1000);
    tick;
    inj_start = '0;
    for (int e = 0; e < 100; e++) tick;
    chk("mid_data", tx_data_out[15:0], 16'h00BC);
    chk("mid_cnt", inj_cnt[15:0], 16'd100);
    chk("mid_busy", busy[0], 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_data", tx_data_out, '0);
    chk("mrst_k", tx_k_out, '0);
    chk("mrst_busy", busy, '0);
    chk("mrst_cnt", inj_cnt, '0);
    chk("mrst_disp", disp, '0);
    tick;
    chk("post_rst_data", tx_data_out[15:0], 16'h1234);
    chk("post_rst_busy", busy[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
